// File: rtl/instr_fetch_queue.sv
// Instruction prefetch queue: credit-limited fetch with fixed 1-cycle memory latency, redirect flush.
// Optional `IFQ_PERF_EN adds perf_fetched / perf_flushed counters.
module instr_fetch_queue #(
    parameter int                ADDR_W   = 64,
    parameter int                INSTR_W  = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = 64'h0000_0000_0004_0000
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc
`ifdef IFQ_PERF_EN
    ,
    output logic [31:0]        perf_fetched,
    output logic [31:0]        perf_flushed
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               inflight_q, inflight_d;
    logic [ADDR_W-1:0]  inflight_pc_q, inflight_pc_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [INSTR_W-1:0] ibuf_q [DEPTH];
    logic [ADDR_W-1:0]  pcbuf_q [DEPTH];

    logic [CNT_W:0]     occupied;
    logic               issue;
    logic               push;
    logic               pop;

    always_comb begin
        // Entries held plus the one in flight act as the credit count.
        occupied      = {1'b0, count_q} + (CNT_W + 1)'(inflight_q);
        issue         = rst && !redirect_valid && (occupied < (CNT_W + 1)'(DEPTH));
        push          = inflight_q && !redirect_valid;
        pop           = (count_q != '0) && instr_ready && !redirect_valid;

        fetch_pc_d    = fetch_pc_q;
        count_d       = count_q;
        inflight_d    = inflight_q;
        inflight_pc_d = inflight_pc_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;

        if (redirect_valid) begin
            fetch_pc_d = redirect_pc & ~ADDR_W'(3);
            count_d    = '0;
            inflight_d = 1'b0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
        end else begin
            if (issue) begin
                fetch_pc_d    = fetch_pc_q + ADDR_W'(4);
                inflight_pc_d = fetch_pc_q;
            end
            inflight_d = issue;
            wr_ptr_d   = wr_ptr_q + PTR_W'(push);
            rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
            count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_q    <= RESET_PC;
            count_q       <= '0;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            count_q       <= count_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
        end
    end

    // Storage needs no reset: entries are only visible while count_q covers them.
    always_ff @(posedge clk) begin
        if (push) begin
            ibuf_q[wr_ptr_q]  <= imem_rdata;
            pcbuf_q[wr_ptr_q] <= inflight_pc_q;
        end
    end

    assign imem_req    = issue;
    assign imem_addr   = fetch_pc_q;
    assign instr_valid = (count_q != '0);
    assign instr       = instr_valid ? ibuf_q[rd_ptr_q]  : '0;
    assign instr_pc    = instr_valid ? pcbuf_q[rd_ptr_q] : '0;

    // The credit rule guarantees a landing slot for every response.
    assert property (@(posedge clk) disable iff (!rst) !(push && (count_q == CNT_W'(DEPTH))));

`ifdef IFQ_PERF_EN
    logic [31:0] perf_fetched_q, perf_fetched_d;
    logic [31:0] perf_flushed_q, perf_flushed_d;

    always_comb begin
        perf_fetched_d = perf_fetched_q + 32'(push);
        perf_flushed_d = perf_flushed_q;
        if (redirect_valid) begin
            perf_flushed_d = perf_flushed_q + 32'(occupied);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_fetched_q <= '0;
            perf_flushed_q <= '0;
        end else begin
            perf_fetched_q <= perf_fetched_d;
            perf_flushed_q <= perf_flushed_d;
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_flushed = perf_flushed_q;
`endif

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Scoreboard bench for instr_fetch_queue: a request monitor pushes expected PCs, pops are checked in order.
module tb_instr_fetch_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic [31:0] imem_rdata = '0;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [63:0] instr_pc;
`ifdef IFQ_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_flushed;
`endif

    int errs   = 0;
    int checks = 0;

    always #5 clk = ~clk;

    instr_fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc)
`ifdef IFQ_PERF_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_flushed   (perf_flushed)
`endif
    );

    function automatic logic [31:0] data_of(input logic [63:0] a);
        return a[31:0] ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // One-cycle-latency memory returning address-derived data.
    always @(posedge clk) begin
        if (imem_req) imem_rdata <= data_of(imem_addr);
    end

    // Scoreboard: every observed request pushes its expected PC; every pop is compared in order.
    logic [63:0] sb_q[$];
    logic [63:0] exp_pc = 64'h4_0000;
    logic        exp_inflight = 1'b0;

    always @(negedge clk) begin
        logic [63:0] h;
        if (!rst) begin
            sb_q.delete();
            exp_pc       = 64'h4_0000;
            exp_inflight = 1'b0;
            chk("rst_req", {63'd0, imem_req}, 64'd0);
            chk("rst_valid", {63'd0, instr_valid}, 64'd0);
        end else begin
            chk("credit", {63'd0, imem_req},
                {63'd0, (!redirect_valid && (sb_q.size() < DEPTH))});
            chk("valid", {63'd0, instr_valid},
                {63'd0, ((sb_q.size() - int'(exp_inflight)) > 0)});
            if (redirect_valid) begin
                sb_q.delete();
                exp_pc       = redirect_pc & ~64'h3;
                exp_inflight = 1'b0;
            end else begin
                if (instr_valid && instr_ready) begin
                    if (sb_q.size() == 0) begin
                        chk("pop_empty", {63'd0, instr_valid}, 64'd0);
                    end else begin
                        h = sb_q.pop_front();
                        chk("pop_pc", instr_pc, h);
                        chk("pop_instr", {32'd0, instr}, {32'd0, data_of(h)});
                    end
                end
                if (imem_req) begin
                    chk("req_addr", imem_addr, exp_pc);
                    sb_q.push_back(exp_pc);
                    exp_pc = exp_pc + 64'd4;
                end
                exp_inflight = imem_req;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic rdy);
        tick();
        rst = 1'b0;
        tick();
        tick();
        instr_ready = rdy;
        rst = 1'b1;
    endtask

    task automatic wait_valid(input string tag);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (instr_valid) break;
        end
        chk(tag, {63'd0, instr_valid}, 64'd1);
    endtask

    initial begin
        int n;
`ifdef IFQ_PERF_EN
        logic [31:0] fl0;
`endif
        rst            = 1'b0;
        instr_ready    = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;

        // Reset state and startup sequence
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_req", {63'd0, imem_req}, 64'd0);
        chk("reset_valid", {63'd0, instr_valid}, 64'd0);
        chk("reset_instr", {32'd0, instr}, 64'd0);
        chk("reset_pc", instr_pc, 64'd0);
`ifdef IFQ_PERF_EN
        chk("reset_perf_f", {32'd0, perf_fetched}, 64'd0);
        chk("reset_perf_x", {32'd0, perf_flushed}, 64'd0);
`endif
        tick();
        rst = 1'b1;
        @(negedge clk);
        chk("c0_addr", imem_addr, 64'h4_0000);
        chk("c0_valid", {63'd0, instr_valid}, 64'd0);
        @(negedge clk);
        chk("c1_addr", imem_addr, 64'h4_0004);
        chk("c1_valid", {63'd0, instr_valid}, 64'd0);
        @(negedge clk);
        chk("c2_addr", imem_addr, 64'h4_0008);
        chk("c2_valid", {63'd0, instr_valid}, 64'd1);
        chk("c2_pc", instr_pc, 64'h4_0000);
        repeat (6) tick();

        // Stalled decode: fill to DEPTH then stop, resume on ready
        do_reset(1'b0);
        n = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (imem_req) n++;
        end
        chk("stall_reqs", 64'(n), 64'(DEPTH));
        chk("stall_idle", {63'd0, imem_req}, 64'd0);
        tick();
        instr_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (imem_req) break;
        end
        chk("resume_addr", imem_addr, 64'h4_0010);
        repeat (8) tick();

        // Redirect with 3 held and 1 in flight
        do_reset(1'b0);
        repeat (4) tick();
`ifdef IFQ_PERF_EN
        fl0 = perf_flushed;
`endif
        redirect_valid = 1'b1;
        redirect_pc    = 64'h4_0103;
        tick();
        redirect_valid = 1'b0;
`ifdef IFQ_PERF_EN
        chk("perf_flushed", {32'd0, perf_flushed - fl0}, 64'd4);
`endif
        @(negedge clk);
        chk("redir_valid", {63'd0, instr_valid}, 64'd0);
        chk("redir_req", {63'd0, imem_req}, 64'd1);
        chk("redir_addr", imem_addr, 64'h4_0100);
        tick();
        instr_ready = 1'b1;
        wait_valid("redir_wait");
        chk("redir_head", instr_pc, 64'h4_0100);
        repeat (4) tick();

        // Full queue, then random decode stalls with concurrent push/pop
        do_reset(1'b0);
        repeat (6) tick();
        for (int i = 0; i < 60; i++) begin
            instr_ready = 1'($urandom_range(0, 1));
            tick();
        end
        instr_ready = 1'b1;
        repeat (6) tick();

        // Asynchronous reset mid-cycle during a request
        @(posedge clk);
        #1;
        chk("pre_rst_req", {63'd0, imem_req}, 64'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("async_req", {63'd0, imem_req}, 64'd0);
        chk("async_valid", {63'd0, instr_valid}, 64'd0);
        chk("async_pc", instr_pc, 64'd0);
        tick();
        tick();
        rst = 1'b1;
        @(negedge clk);
        chk("restart_addr", imem_addr, 64'h4_0000);
        repeat (6) tick();

        // Back-to-back redirects: only the last target is fetched
        redirect_valid = 1'b1;
        redirect_pc    = 64'h4_0200;
        tick();
        redirect_pc    = 64'h4_0300;
        tick();
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("b2b_req", {63'd0, imem_req}, 64'd1);
        chk("b2b_addr", imem_addr, 64'h4_0300);
        wait_valid("b2b_wait");
        chk("b2b_head", instr_pc, 64'h4_0300);
        repeat (8) tick();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the end");
        $fatal(1);
    end

endmodule
